// File: rtl/execute_muldiv.sv
// ============================================================================
// execute_muldiv
// ----------------------------------------------------------------------------
// Iterative RISC-V M-extension unit for the execute stage. Multiplies use a
// shift-add loop (one multiplier bit per cycle) and divides use a restoring
// loop (one quotient bit per cycle). Both loops run on operand magnitudes; the
// sign of the result is applied once, when the final value is selected.
// Divide-by-zero and signed overflow bypass the loop and finish in one cycle.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   asynchronous active-high reset
//   start        in   1   request a new operation this cycle
//   op           in   3   funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   rs_data1     in  32   multiplicand / dividend
//   rs_data2     in  32   multiplier / divisor
//   rd_in        in   5   destination register tag
//   flush        in   1   kill any in-flight operation
//   stall        out  1   pipeline hold request (combinational)
//   busy         out  1   iterating (registered)
//   result_valid out  1   one-cycle result strobe (registered)
//   result       out 32   operation result (held between strobes)
//   result_rd    out  5   destination tag of result (held between strobes)
// ============================================================================
module execute_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data1,
    input  logic [31:0] rs_data2,
    input  logic [4:0]  rd_in,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] result,
    output logic [4:0]  result_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [5:0]  count;
    logic [2:0]  op_q;
    logic [4:0]  rd_q;
    logic        neg_q;      // negate product / quotient
    logic        neg_r;      // negate remainder
    // Multiply: upper half accumulates, lower half holds the remaining
    // multiplier bits. Divide: lower half holds dividend bits shifting out
    // while quotient bits shift in.
    logic [63:0] acc;
    logic [31:0] divisor;    // multiplicand magnitude for MUL*, divisor for DIV*
    logic [32:0] rem;

    // ------------------------------------------------------------------
    // Operand decode for a new request
    // ------------------------------------------------------------------
    logic        a_signed, b_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        accept, div_zero, div_ovf, fast;
    logic [31:0] fast_result;

    always_comb begin
        a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        a_neg    = a_signed & rs_data1[31];
        b_neg    = b_signed & rs_data2[31];
        a_mag    = a_neg ? (32'd0 - rs_data1) : rs_data1;
        b_mag    = b_neg ? (32'd0 - rs_data2) : rs_data2;
        accept   = start & ~flush & ((state == IDLE) || (state == DONE));
        div_zero = op[2] & (rs_data2 == 32'd0);
        div_ovf  = op[2] & ~op[0] & (rs_data1 == 32'h8000_0000) & (rs_data2 == 32'hFFFF_FFFF);
        fast     = div_zero | div_ovf;
        // op[1] separates REM/REMU from DIV/DIVU
        if (div_zero)
            fast_result = op[1] ? rs_data1 : 32'hFFFF_FFFF;
        else
            fast_result = op[1] ? 32'd0 : 32'h8000_0000;
    end

    // ------------------------------------------------------------------
    // One iteration of each loop, plus the signed final value computed
    // from the post-iteration state so the last step can retire directly.
    // ------------------------------------------------------------------
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [63:0] mul_prod;
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic        div_ok;
    logic [32:0] div_rem_next;
    logic [31:0] div_quo_next;
    logic [31:0] div_q, div_r;
    logic [31:0] final_result;

    always_comb begin
        mul_sum      = {1'b0, acc[63:32]} + {1'b0, divisor};
        mul_next     = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};
        mul_prod     = neg_q ? (64'd0 - mul_next) : mul_next;

        div_shift    = {rem[31:0], acc[31]};
        div_diff     = {1'b0, div_shift} - {2'b00, divisor};
        div_ok       = ~div_diff[33];
        div_rem_next = div_ok ? div_diff[32:0] : div_shift;
        div_quo_next = {acc[30:0], div_ok};
        div_q        = neg_q ? (32'd0 - div_quo_next) : div_quo_next;
        div_r        = neg_r ? (32'd0 - div_rem_next[31:0]) : div_rem_next[31:0];

        if (op_q[2])
            final_result = op_q[1] ? div_r : div_q;
        else if (op_q[1:0] == 2'b00)
            final_result = mul_prod[31:0];
        else
            final_result = mul_prod[63:32];
    end

    // The partial remainder never reaches 2^32 once stored, so its top bit
    // only exists to hold the full-width restoring step.
    logic unused_rem_msb;
    assign unused_rem_msb = rem[32];

    // Hold the pipeline while a request is being accepted or while iterating.
    assign stall = ~rst & ((start & ~flush & ((state == IDLE) || (state == DONE)))
                           | (state == BUSY));

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            count        <= 6'd0;
            op_q         <= 3'd0;
            rd_q         <= 5'd0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            acc          <= 64'd0;
            divisor      <= 32'd0;
            rem          <= 33'd0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= 32'd0;
            result_rd    <= 5'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                    if (accept) begin
                        op_q  <= op;
                        rd_q  <= rd_in;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        count <= 6'd0;
                        rem   <= 33'd0;
                        if (op[2]) begin
                            acc     <= {32'd0, a_mag};
                            divisor <= b_mag;
                        end else begin
                            acc     <= {32'd0, b_mag};
                            divisor <= a_mag;
                        end
                        if (fast) begin
                            state        <= DONE;
                            result_valid <= 1'b1;
                            result       <= fast_result;
                            result_rd    <= rd_in;
                        end else begin
                            state <= BUSY;
                            busy  <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        count <= count + 6'd1;
                        if (op_q[2]) begin
                            acc <= {acc[63:32], div_quo_next};
                            rem <= div_rem_next;
                        end else begin
                            acc <= mul_next;
                        end
                        if (count == 6'd31) begin
                            state        <= DONE;
                            busy         <= 1'b0;
                            result_valid <= 1'b1;
                            result       <= final_result;
                            result_rd    <= rd_q;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_execute_muldiv.sv
// ============================================================================
// tb_execute_muldiv
// ----------------------------------------------------------------------------
// Self-checking bench for execute_muldiv. Expected results come from a plain
// 64-bit arithmetic model of the RISC-V M-extension rules; expected latency
// is 1 cycle for divide-by-zero / signed overflow and 33 cycles otherwise.
// ============================================================================
module tb_execute_muldiv;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data1;
    logic [31:0] rs_data2;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  result_rd;

    int checkCount = 0;
    int passCount  = 0;

    execute_muldiv dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .rs_data1     (rs_data1),
        .rs_data2     (rs_data2),
        .rd_in        (rd_in),
        .flush        (flush),
        .stall        (stall),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .result_rd    (result_rd)
    );

    // Free-running 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    // Reference model: M-extension result from 64-bit arithmetic
    function automatic logic [31:0] refResult(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic        [63:0] ua, ub, up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            3'd0: begin up = ua * ub; return up[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                sp = sa / sb; return sp[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                sp = sa % sb; return sp[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] o, input logic [31:0] a,
                                      input logic [31:0] b);
        if (o[2] && b == 32'd0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic driveStart(input logic [2:0] o, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd);
        start    = 1'b1;
        op       = o;
        rs_data1 = a;
        rs_data2 = b;
        rd_in    = rd;
    endtask

    // Advance cycle by cycle until result_valid, bounded to 40 cycles
    task automatic waitResult(output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (result_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    // Issue one operation from IDLE and check stall, latency, value, tag,
    // one-cycle strobe and held outputs afterwards
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd,
                                 input string tag);
        int          lat;
        logic [31:0] expRes;
        expRes = refResult(o, a, b);
        driveStart(o, a, b, rd);
        #1;
        checkOutput({tag, " stall@0"}, 64'(stall), 64'd1);
        waitResult(lat);
        checkOutput({tag, " latency"}, 64'(lat), 64'(refLatency(o, a, b)));
        checkOutput({tag, " result"}, 64'(result), 64'(expRes));
        checkOutput({tag, " result_rd"}, 64'(result_rd), 64'(rd));
        @(posedge clk); #1;
        checkOutput({tag, " valid drop"}, 64'(result_valid), 64'd0);
        checkOutput({tag, " result hold"}, 64'(result), 64'(expRes));
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            4: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    int          lat;
    logic        sawValid;
    logic [31:0] ra, rb, expA, expB;
    logic [2:0]  ro;

    initial begin
        // ---------------- reset state, stall masked during reset ----------
        rst = 1'b1;
        flush = 1'b0;
        driveStart(3'd0, 32'd7, 32'd3, 5'd1);
        #2;
        checkOutput("reset stall", 64'(stall), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset valid", 64'(result_valid), 64'd0);
        checkOutput("reset result", 64'(result), 64'd0);
        checkOutput("reset rd", 64'(result_rd), 64'd0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // ---------------- MUL 7 x 0xFFFFFFFD: full cycle-by-cycle profile -
        driveStart(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        #1;
        checkOutput("mul stall c0", 64'(stall), 64'd1);
        for (int c = 1; c <= 34; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            checkOutput($sformatf("mul stall c%0d", c), 64'(stall), 64'(c <= 32));
            checkOutput($sformatf("mul busy c%0d", c), 64'(busy), 64'(c <= 32));
            checkOutput($sformatf("mul valid c%0d", c), 64'(result_valid), 64'(c == 33));
            if (c == 33) begin
                checkOutput("mul result", 64'(result), 64'h0000_0000_FFFF_FFEB);
                checkOutput("mul result_rd", 64'(result_rd), 64'd5);
            end
        end

        // ---------------- directed corner cases ---------------------------
        applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, "mulhu -1*-1");
        applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, "mulh -1*-1");
        applyStimulus(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4, "mulhsu -1*2");
        applyStimulus(3'd5, 32'd100, 32'd0, 5'd6, "divu by0");
        applyStimulus(3'd7, 32'd100, 32'd0, 5'd7, "remu by0");
        applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, "div ovf");
        applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, "rem ovf");
        applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, "div -7/2");
        applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, "rem -7/2");
        applyStimulus(3'd5, 32'hFFFF_FFF9, 32'd2, 5'd12, "divu big/2");
        // Model constants cross-checked against known answers
        checkOutput("model mulhu", 64'(refResult(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'hFFFF_FFFE);
        checkOutput("model div", 64'(refResult(3'd4, 32'hFFFF_FFF9, 32'd2)), 64'hFFFF_FFFD);

        // ---------------- flush in cycle 10 of a DIV ----------------------
        driveStart(3'd4, 32'd1000, 32'd7, 5'd13);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 10) flush = 1'b1;
        end
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        checkOutput("flush busy c11", 64'(busy), 64'd0);
        checkOutput("flush stall c11", 64'(stall), 64'd0);
        checkOutput("flush valid c11", 64'(result_valid), 64'd0);
        sawValid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (result_valid) sawValid = 1'b1;
        end
        checkOutput("flush no result", 64'(sawValid), 64'd0);
        applyStimulus(3'd4, 32'd1000, 32'd7, 5'd14, "div after flush");

        // ---------------- flush coincident with start cancels it ----------
        driveStart(3'd0, 32'd3, 32'd3, 5'd15);
        flush = 1'b1;
        #1;
        checkOutput("flush+start stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        checkOutput("flush+start busy", 64'(busy), 64'd0);

        // ---------------- back-to-back start in DONE ----------------------
        expA = refResult(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
        expB = refResult(3'd5, 32'hDEAD_BEEF, 32'd12345);
        driveStart(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd16);
        waitResult(lat);
        checkOutput("b2b first latency", 64'(lat), 64'd33);
        checkOutput("b2b first result", 64'(result), 64'(expA));
        driveStart(3'd5, 32'hDEAD_BEEF, 32'd12345, 5'd17);
        #1;
        checkOutput("b2b stall in done", 64'(stall), 64'd1);
        waitResult(lat);
        checkOutput("b2b second latency", 64'(lat), 64'd33);
        checkOutput("b2b second result", 64'(result), 64'(expB));
        checkOutput("b2b second rd", 64'(result_rd), 64'd17);
        @(posedge clk); #1;

        // ---------------- reset pulse in cycle 15 -------------------------
        driveStart(3'd6, 32'hFFFF_0000, 32'd37, 5'd18);
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        checkOutput("rst mid busy", 64'(busy), 64'd0);
        checkOutput("rst mid valid", 64'(result_valid), 64'd0);
        checkOutput("rst mid result", 64'(result), 64'd0);
        checkOutput("rst mid rd", 64'(result_rd), 64'd0);
        checkOutput("rst mid stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        sawValid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (result_valid || busy) sawValid = 1'b1;
        end
        checkOutput("rst mid no result", 64'(sawValid), 64'd0);

        // ---------------- randomized operations ---------------------------
        for (int i = 0; i < 150; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = pickOperand();
            rb = pickOperand();
            if (i % 17 == 0) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            applyStimulus(ro, ra, rb, 5'($urandom_range(0, 31)), $sformatf("rand%0d op%0d", i, ro));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/execute_muldiv.md
EXECUTE_MULDIV -- requirements
Module: execute_muldiv

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 The port list SHALL be, one port per line as name, direction, width, meaning:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  request a new M-extension operation this cycle
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs_data1  in  32  operand 1 (multiplicand/dividend)
- rs_data2  in  32  operand 2 (multiplier/divisor)
- rd_in  in  5  destination register tag
- flush  in  1  kill any in-flight operation
- stall  out  1  pipeline hold request (combinational)
- busy  out  1  iterating (registered)
- result_valid  out  1  one-cycle result strobe (registered)
- result  out  32  operation result
- result_rd  out  5  destination tag of result

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-004 start SHALL be accepted only in IDLE or DONE, and only with flush low; on acceptance the block SHALL latch op, rd_in, operand magnitudes and sign flags.
REQ-005 Signed handling:
- MULH treats both operands as signed.
- MULHSU treats rs_data1 as signed and rs_data2 as unsigned.
- DIV and REM treat both operands as signed.
- All other ops are unsigned.
REQ-006 Multiply SHALL be shift-add, one bit per cycle, 32 iterations, into a 64-bit accumulator; the product SHALL be negated when the operand signs differ.
REQ-007 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32].
REQ-008 Divide SHALL be restoring, one quotient bit per cycle, 32 iterations.
REQ-009 Division result signs: quotient negated when the operand signs differ (DIV); remainder takes the sign of the dividend (REM).
REQ-010 Divide by zero SHALL take a fast path straight to DONE:
- DIV/DIVU return 0xFFFFFFFF.
- REM/REMU return rs_data1.
REQ-011 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL take the fast path: DIV returns 0x80000000, REM returns 0.
REQ-012 Latency, with start accepted in cycle 0:
- normal path: busy high cycles 1-32, result_valid high in cycle 33 only.
- fast path: result_valid high in cycle 1 only.
REQ-013 stall SHALL equal (start & ~flush & state in {IDLE, DONE}) | (state == BUSY).
REQ-014 The iteration counter SHALL be 6 bits, cleared on accept, and SHALL exit BUSY to DONE after the 32nd iteration.
REQ-015 DONE SHALL last exactly one cycle, then go to IDLE, unless a new start is accepted in DONE (back-to-back), which goes to BUSY or to DONE via the fast path.
REQ-016 result and result_rd SHALL hold their last values outside result_valid cycles.
REQ-017 start while in BUSY SHALL be ignored.
REQ-018 flush while in BUSY or DONE SHALL force IDLE at the next edge; result_valid SHALL be 0 in the following cycle and no result SHALL be produced.
REQ-019 flush coincident with start SHALL cancel the start.
REQ-020 The accumulator, divisor and remainder widths SHALL be 64, 32 and 33 bits; no intermediate SHALL be truncated before the final selection.

Reset
REQ-021 Asserting rst SHALL immediately force IDLE and clear: counter, busy, result_valid, result = 0, result_rd = 0, and all datapath registers.
REQ-022 Reset asserted mid-operation SHALL discard the operation; no result_valid SHALL follow release.
REQ-023 stall SHALL be 0 during reset regardless of start.

Verification
REQ-024 MUL 7 x 0xFFFFFFFD, rd = 5, start in cycle 0 -> result_valid only in cycle 33, result 0xFFFFFFEB, result_rd 5; stall high cycles 0-32.
REQ-025 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH of the same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-026 DIVU 100 / 0 -> result_valid in cycle 1 with 0xFFFFFFFF; REMU 100 / 0 -> 100; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-027 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
REQ-028 flush in cycle 10 of a DIV -> IDLE in cycle 11, stall 0 in cycle 11, no result_valid; next start is accepted normally.
REQ-029 Back-to-back: second start asserted in the DONE cycle -> second result_valid exactly 33 cycles later; rst pulse in cycle 15 -> all outputs 0 and no result_valid afterwards.
